bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Central arbiter for the serial bus. Collects `approval_request` from up to NUM_MASTERS master ports and issues a one-hot `approval_grant` to a single owner using round-robin order. Holds ownership until that master's `trans_done` and drives the shared `arbitor_busy` / `bus_busy` status lines back to all master ports. Provides the owner index for the bus multiplexer, plus a watchdog that forcibly reclaims the bus from a hung master.

## Interface
Parameters:
- NUM_MASTERS, 2, number of master ports (≥2)
- TIMEOUT, 4096, maximum cycles a master may hold the bus in BUSY before forced release (≥2)
- IDX_W, $clog2(NUM_MASTERS), width of the owner index

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- approval_request  in  NUM_MASTERS  per-master bus request, level, held until granted
- trans_done  in  NUM_MASTERS  per-master transaction-complete
- approval_grant  out  NUM_MASTERS  one-hot (or zero) grant to the owner
- arbitor_busy  out  1  arbiter is mid-cycle (GRANT/BUSY/RELEASE)
- bus_busy  out  1  owner is actively using the bus
- grant_idx  out  IDX_W  index of the current or most recent owner (bus mux select)
- grant_valid  out  1  `grant_idx` refers to a live grant
- timeout_err  out  1  one-cycle pulse on watchdog release

## Operation
- Moore FSM; all outputs are registered and decoded from state plus `owner`.
- IDLE: grant=0, arbitor_busy=0, bus_busy=0, grant_valid=0. If any request bit is set, pick the first set bit searching from `last+1` upward with wrap, load `owner`, go to GRANT.
- GRANT (1 cycle): grant[owner]=1, arbitor_busy=1, bus_busy=0, grant_valid=1.
  - If approval_request[owner]=1 → BUSY.
  - Otherwise the request was withdrawn → RELEASE.
- BUSY: grant[owner]=1, arbitor_busy=1, bus_busy=1, grant_valid=1. Watchdog counter increments each cycle.
  - trans_done[owner]=1 → RELEASE.
  - Otherwise, counter reaching TIMEOUT-1 → RELEASE with timeout_err pulse.
- RELEASE (1 cycle): grant=0, arbitor_busy=1, bus_busy=0, grant_valid=0. Set `last`=owner, clear watchdog, go to IDLE.
- Only trans_done[owner] is honoured. trans_done from non-owners, and trans_done in IDLE, GRANT or RELEASE, is ignored.
- Requests arriving in GRANT, BUSY or RELEASE are not sampled. They are considered in the next IDLE.
- Round-robin: a master that has just been served has lowest priority next arbitration. A sole requester may be re-granted back-to-back.
- Watchdog: counter width $clog2(TIMEOUT). Cleared on entry to BUSY. It never wraps because it is forced to release at TIMEOUT-1.
- Reset (reset=0 at a clock edge), including mid-transaction:
  - state=IDLE, owner=0, last=NUM_MASTERS-1 (so master 0 wins first), counter=0.
  - Outputs: approval_grant=0, arbitor_busy=0, bus_busy=0, grant_idx=0, grant_valid=0, timeout_err=0.

## Timing
- Request high in IDLE at edge t → grant high from t+1 (GRANT), bus_busy high from t+2.
- trans_done[owner] sampled at edge k in BUSY → grant and bus_busy low from k+1 (RELEASE), IDLE at k+2. Earliest next grant is k+3.
- Minimum ownership is 3 cycles: GRANT, BUSY, RELEASE. Bus turnaround is 2 dead cycles between owners.
- Timeout: BUSY entered at edge b with no trans_done → RELEASE at b+TIMEOUT. timeout_err is high during that RELEASE cycle only.
- grant_idx keeps its last value through RELEASE and IDLE; grant_valid qualifies it.

## Structure
- Shared package `serial_bus_pkg`: `arb_state_t` enum {IDLE, GRANT, BUSY, RELEASE} and the default TIMEOUT constant.
- Sub-module `rr_picker`: purely combinational. Inputs are the request vector and `last`; outputs are a found flag and the next index. It is parameterised by NUM_MASTERS and reusable by a future slave-side arbiter.
- Top level contains the FSM, the owner/last registers, the watchdog counter and the output decode.

## Test plan
- Reset mid-BUSY (owner=1): all outputs 0 the next cycle. Then request=2'b11 → grant=2'b01 (last reset to 1).
- request=2'b01 held, trans_done[0] asserted 5 cycles after grant → grant 2'b01 for GRANT+5 BUSY cycles, then RELEASE. Re-grant 2'b01 three cycles after trans_done is sampled.
- request=2'b11 continuous, each owner completes → grant alternates 01,10,01,10. grant_idx 0,1,0,1; no master starves.
- Owner 0 in BUSY with trans_done=2'b10 (non-owner) → ignored, grant stays 2'b01, bus_busy stays 1.
- TIMEOUT=8, owner never asserts trans_done → RELEASE exactly 8 cycles after BUSY entry. timeout_err is a 1-cycle pulse; the next requester is then granted.
- Master 1 drops its request during GRANT → RELEASE with no BUSY cycle, bus_busy never asserts, last=1.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared arbitration state type and defaults for the serial bus
package serial_bus_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} arb_state_t;
    localparam int DEFAULT_TIMEOUT = 4096;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant/status bundle between master ports and the arbiter
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] approval_request;
    logic [NUM_MASTERS-1:0] trans_done;
    logic [NUM_MASTERS-1:0] approval_grant;
    logic arbitor_busy;
    logic bus_busy;
    logic [IDX_W-1:0] grant_idx;
    logic grant_valid;
    logic timeout_err;
    modport slave (
        input approval_request, trans_done,
        output approval_grant, arbitor_busy, bus_busy, grant_idx, grant_valid, timeout_err
    );
    modport master (
        output approval_request, trans_done,
        input approval_grant, arbitor_busy, bus_busy, grant_idx, grant_valid, timeout_err
    );
endinterface

// File: rtl/rr_picker.sv
// rr_picker: finds the first set request bit after last, wrapping around
module rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   found,
    output logic [IDX_W-1:0]       idx
);
    always_comb begin
        found = 1'b0;
        idx = '0;
        // walk farthest-first so the nearest candidate after last wins
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (req[IDX_W'((int'(last) + i) % NUM_MASTERS)]) begin
                found = 1'b1;
                idx = IDX_W'((int'(last) + i) % NUM_MASTERS);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus ownership FSM with hung-master watchdog
module bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int IDX_W = $clog2(NUM_MASTERS)
) (
    input logic clk,
    input logic reset,
    bus_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    arb_state_t state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic tmo_q, tmo_d, pick_found;
    rr_picker #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_pick (
        .req(bus.approval_request),
        .last(last_q),
        .found(pick_found),
        .idx(pick_idx)
    );
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d = last_q;
        cnt_d = '0;
        tmo_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: state_d = bus.approval_request[owner_q] ? BUSY : RELEASE;
            BUSY: begin
                if (bus.trans_done[owner_q]) state_d = RELEASE;
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RELEASE;
                    tmo_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            RELEASE: begin
                last_d = owner_q;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q <= IDX_W'(NUM_MASTERS - 1);
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q <= last_d;
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign bus.approval_grant = (state_q == GRANT || state_q == BUSY)
                              ? ({{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign bus.arbitor_busy = state_q != IDLE;
    assign bus.bus_busy = state_q == BUSY;
    assign bus.grant_idx = owner_q;
    assign bus.grant_valid = state_q == GRANT || state_q == BUSY;
    assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed cycle tables for bus_arbiter with TIMEOUT=8
module tb_bus_arbiter;
    typedef struct packed {
        logic [1:0] req;
        logic [1:0] done;
        logic [6:0] exp;
    } vec_t;
    // status = {grant[1:0], arbitor_busy, bus_busy, grant_idx, grant_valid, timeout_err}
    localparam logic [6:0] IDL0 = 7'b0000000, G0 = 7'b0110010, B0 = 7'b0111010, R0 = 7'b0010000;
    localparam logic [6:0] IDL1 = 7'b0000100, G1 = 7'b1010110, B1 = 7'b1011110, R1 = 7'b0010100;
    localparam logic [6:0] R1T = 7'b0010101;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [6:0] st;
    bus_arbiter_if #(.NUM_MASTERS(2), .IDX_W(1)) bus ();
    bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT(8), .IDX_W(1)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    assign st = {bus.approval_grant, bus.arbitor_busy, bus.bus_busy, bus.grant_idx, bus.grant_valid, bus.timeout_err};

    task automatic test_reset();
        logic rs [9];
        vec_t v [9];
        rs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        v = '{'{2'b00, 2'b00, IDL0}, '{2'b10, 2'b00, IDL0}, '{2'b10, 2'b00, G1},
              '{2'b00, 2'b00, B1}, '{2'b11, 2'b00, IDL0}, '{2'b11, 2'b00, G0},
              '{2'b10, 2'b01, B0}, '{2'b00, 2'b00, R0}, '{2'b00, 2'b00, IDL0}};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_checks++;
            if (st !== v[i].exp) begin
                $display("FAIL reset[%0d]: status got %b expected %b", i, st, v[i].exp);
                n_fail++;
            end
            reset = rs[i];
            bus.approval_request = v[i].req;
            bus.trans_done = v[i].done;
        end
    endtask

    task automatic test_single();
        vec_t v [12];
        v = '{'{2'b01, 2'b00, IDL0}, '{2'b01, 2'b00, G0}, '{2'b01, 2'b00, B0},
              '{2'b01, 2'b00, B0}, '{2'b01, 2'b00, B0}, '{2'b01, 2'b00, B0},
              '{2'b01, 2'b01, B0}, '{2'b01, 2'b00, R0}, '{2'b01, 2'b00, IDL0},
              '{2'b00, 2'b00, G0}, '{2'b00, 2'b00, R0}, '{2'b00, 2'b00, IDL0}};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (st !== v[i].exp) begin
                $display("FAIL single[%0d]: status got %b expected %b", i, st, v[i].exp);
                n_fail++;
            end
            bus.approval_request = v[i].req;
            bus.trans_done = v[i].done;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [17];
        v = '{'{2'b11, 2'b00, IDL0}, '{2'b11, 2'b00, G1}, '{2'b11, 2'b10, B1},
              '{2'b11, 2'b00, R1}, '{2'b11, 2'b00, IDL1}, '{2'b11, 2'b00, G0},
              '{2'b11, 2'b01, B0}, '{2'b11, 2'b00, R0}, '{2'b11, 2'b00, IDL0},
              '{2'b11, 2'b00, G1}, '{2'b11, 2'b10, B1}, '{2'b11, 2'b00, R1},
              '{2'b11, 2'b00, IDL1}, '{2'b11, 2'b00, G0}, '{2'b11, 2'b01, B0},
              '{2'b00, 2'b00, R0}, '{2'b00, 2'b00, IDL0}};
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            n_checks++;
            if (st !== v[i].exp) begin
                $display("FAIL back_to_back[%0d]: status got %b expected %b", i, st, v[i].exp);
                n_fail++;
            end
            bus.approval_request = v[i].req;
            bus.trans_done = v[i].done;
        end
    endtask

    task automatic test_foreign_done();
        vec_t v [7];
        v = '{'{2'b01, 2'b00, IDL0}, '{2'b01, 2'b01, G0}, '{2'b01, 2'b10, B0},
              '{2'b01, 2'b10, B0}, '{2'b01, 2'b01, B0}, '{2'b00, 2'b00, R0},
              '{2'b00, 2'b00, IDL0}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++;
            if (st !== v[i].exp) begin
                $display("FAIL foreign_done[%0d]: status got %b expected %b", i, st, v[i].exp);
                n_fail++;
            end
            bus.approval_request = v[i].req;
            bus.trans_done = v[i].done;
        end
    endtask

    task automatic test_timeout();
        vec_t v [16];
        v = '{'{2'b11, 2'b00, IDL0}, '{2'b11, 2'b00, G1}, '{2'b11, 2'b00, B1},
              '{2'b11, 2'b00, B1}, '{2'b11, 2'b00, B1}, '{2'b11, 2'b00, B1},
              '{2'b11, 2'b00, B1}, '{2'b11, 2'b00, B1}, '{2'b11, 2'b00, B1},
              '{2'b11, 2'b00, B1}, '{2'b01, 2'b00, R1T}, '{2'b01, 2'b00, IDL1},
              '{2'b01, 2'b00, G0}, '{2'b01, 2'b01, B0}, '{2'b00, 2'b00, R0},
              '{2'b00, 2'b00, IDL0}};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (st !== v[i].exp) begin
                $display("FAIL timeout[%0d]: status got %b expected %b", i, st, v[i].exp);
                n_fail++;
            end
            bus.approval_request = v[i].req;
            bus.trans_done = v[i].done;
        end
    endtask

    task automatic test_withdraw();
        vec_t v [8];
        v = '{'{2'b10, 2'b00, IDL0}, '{2'b00, 2'b00, G1}, '{2'b00, 2'b00, R1},
              '{2'b11, 2'b00, IDL1}, '{2'b01, 2'b00, G0}, '{2'b01, 2'b01, B0},
              '{2'b00, 2'b00, R0}, '{2'b00, 2'b00, IDL0}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (st !== v[i].exp) begin
                $display("FAIL withdraw[%0d]: status got %b expected %b", i, st, v[i].exp);
                n_fail++;
            end
            bus.approval_request = v[i].req;
            bus.trans_done = v[i].done;
        end
    endtask

    initial begin
        bus.approval_request = '0;
        bus.trans_done = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_foreign_done();
        test_timeout();
        test_withdraw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
